// File: rtl/alu_seq.sv
// Sequential ALU for the UART calculator: single-cycle add/sub, WIDTH-cycle
// shift-add multiply and restoring divide on operand magnitudes.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 parser_done,
    input  logic [3:0]           dtype,
    input  logic [4:0]           operator,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 alu_busy,
    output logic                 alu_done,
    output logic                 alu_err,
    output logic [2*WIDTH-1:0]   calc_res
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, done_q, err_q, err_d;
    logic [2*WIDTH-1:0]   res_q, res_d;

    logic [3:0]           dtype_q;
    logic [4:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q, sh_q;
    logic                 sa_q, sb_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        mag = neg ? -v : v;
    endfunction

    logic start, sa_in, sb_in, is_div_in;
    assign start     = (state_q == IDLE) && parser_done;
    assign sa_in     = (dtype == 4'h1) && src1[WIDTH-1];
    assign sb_in     = (dtype == 4'h1) && src2[WIDTH-1];
    assign is_div_in = (operator == 5'h04);

    logic signed_op, illegal, divz, single, last;
    assign signed_op = (dtype_q == 4'h1);
    assign illegal   = !((dtype_q == 4'h1 || dtype_q == 4'h2) && op_q >= 5'h01 && op_q <= 5'h04);
    assign divz      = (op_q == 5'h04) && (b_q == '0);
    assign single    = illegal || divz || (op_q == 5'h01) || (op_q == 5'h02);
    assign last      = single || (cnt_q == LAST);

    logic signed [WIDTH:0] ext_a, ext_b, sum;
    logic [2*WIDTH-1:0]    addsub_res, mul_acc;
    logic [WIDTH:0]        rem_sh, rem_nx;
    logic                  fits;
    logic [WIDTH-1:0]      quo_nx, quo_fin, rem_fin;

    always_comb begin
        ext_a      = signed_op ? $signed({a_q[WIDTH-1], a_q}) : $signed({1'b0, a_q});
        ext_b      = signed_op ? $signed({b_q[WIDTH-1], b_q}) : $signed({1'b0, b_q});
        sum        = (op_q == 5'h01) ? (ext_a + ext_b) : (ext_a - ext_b);
        addsub_res = signed_op ? {{(WIDTH-1){sum[WIDTH]}}, sum} : {{(WIDTH-1){1'b0}}, sum};
        mul_acc    = acc_q + (sh_q[0] ? mcand_q : '0);
        // Partial remainder lives in acc_q[WIDTH:0]; dividend bits shift out of sh_q.
        rem_sh     = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        fits       = (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]});
        rem_nx     = fits ? (rem_sh - {1'b0, mcand_q[WIDTH-1:0]}) : rem_sh;
        quo_nx     = {sh_q[WIDTH-2:0], fits};
        quo_fin    = (sa_q ^ sb_q) ? -quo_nx : quo_nx;
        rem_fin    = sa_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    end

    logic [2*WIDTH-1:0] exec_res;
    logic               exec_err;

    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        if (illegal) begin
            exec_err = 1'b1;
        end else if (divz) begin
            exec_res = '1;
            exec_err = 1'b1;
        end else begin
            case (op_q)
                5'h01, 5'h02: exec_res = addsub_res;
                5'h03:        exec_res = (sa_q ^ sb_q) ? -mul_acc : mul_acc;
                default:      exec_res = {quo_fin, rem_fin};
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (parser_done) begin
                state_d = EXEC;
                cnt_d   = '0;
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    res_d   = exec_res;
                    err_d   = exec_err;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    // Operand capture and iterative datapath; no reset needed on these.
    always_ff @(posedge clk) begin
        if (start) begin
            dtype_q <= dtype;
            op_q    <= operator;
            a_q     <= src1;
            b_q     <= src2;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, is_div_in ? mag(src2, sb_in) : mag(src1, sa_in)};
            sh_q    <= is_div_in ? mag(src1, sa_in) : mag(src2, sb_in);
        end else if (state_q == EXEC) begin
            if (op_q == 5'h03) begin
                acc_q   <= mul_acc;
                mcand_q <= mcand_q << 1;
                sh_q    <= sh_q >> 1;
            end else if (op_q == 5'h04) begin
                acc_q <= {{(WIDTH-1){1'b0}}, rem_nx};
                sh_q  <= quo_nx;
            end
        end
    end

    assign alu_busy = busy_q;
    assign alu_done = done_q;
    assign alu_err  = err_q;
    assign calc_res = res_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): latency, results, errors and protocol.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        parser_done = 1'b0;
    logic [3:0]  dtype = 4'h0;
    logic [4:0]  operator = 5'h00;
    logic [15:0] src1 = 16'h0;
    logic [15:0] src2 = 16'h0;
    logic        alu_busy, alu_done, alu_err;
    logic [31:0] calc_res;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .n_rst(n_rst), .parser_done(parser_done),
        .dtype(dtype), .operator(operator), .src1(src1), .src2(src2),
        .alu_busy(alu_busy), .alu_done(alu_done), .alu_err(alu_err),
        .calc_res(calc_res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in cycle k+1 (first EXEC cycle) with inputs scrambled.
    task automatic start_op(input logic [3:0] dt, input logic [4:0] op,
                            input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dtype = dt; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        dtype = 4'h5; operator = 5'h1f; src1 = ~a; src2 = ~b;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!alu_done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] dt, input logic [4:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input int lat, input logic [31:0] eres, input logic eerr);
        int n;
        start_op(dt, op, a, b);
        chk({tag, " busy@k+1"}, alu_busy, 1'b1);
        wait_done(1, n);
        chk({tag, " latency"}, n, lat);
        chk({tag, " res"}, calc_res, eres);
        chk({tag, " err"}, alu_err, eerr);
        @(negedge clk);
        chk({tag, " done pulse"}, {alu_done, alu_busy}, 2'b00);
        chk({tag, " res held"}, calc_res, eres);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] held;

        repeat (2) @(negedge clk);
        chk("reset outs", {alu_busy, alu_done, alu_err, calc_res}, 35'h0);
        n_rst = 1'b1;

        do_op("sadd",      4'h1, 5'h01, 16'hFFFE, 16'h0005,  2, 32'h00000003, 1'b0);
        do_op("usub",      4'h2, 5'h02, 16'h0003, 16'h0005,  2, 32'h0001FFFE, 1'b0);
        do_op("ssub min",  4'h1, 5'h02, 16'h8000, 16'h0001,  2, 32'hFFFF7FFF, 1'b0);
        do_op("smul",      4'h1, 5'h03, 16'hFFFD, 16'h0007, 17, 32'hFFFFFFEB, 1'b0);
        do_op("udiv",      4'h2, 5'h04, 16'd100,  16'd7,    17, 32'h000E0002, 1'b0);
        do_op("sdiv neg",  4'h1, 5'h04, 16'hFFF9, 16'h0002, 17, 32'hFFFDFFFF, 1'b0);
        do_op("sdiv negb", 4'h1, 5'h04, 16'h0007, 16'hFFFE, 17, 32'hFFFD0001, 1'b0);
        do_op("sdiv wrap", 4'h1, 5'h04, 16'h8000, 16'hFFFF, 17, 32'h80000000, 1'b0);
        do_op("divzero",   4'h2, 5'h04, 16'h1234, 16'h0000,  2, 32'hFFFFFFFF, 1'b1);
        do_op("sadd clr",  4'h1, 5'h01, 16'h7FFF, 16'h0001,  2, 32'h00008000, 1'b0);
        do_op("bad dtype", 4'h3, 5'h01, 16'h0001, 16'h0001,  2, 32'h00000000, 1'b1);
        do_op("umul max",  4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE0001, 1'b0);
        do_op("bad op",    4'h1, 5'h05, 16'h0001, 16'h0001,  2, 32'h00000000, 1'b1);

        // Reset in the middle of a multiply: outputs clear, no done appears.
        start_op(4'h2, 5'h03, 16'h0010, 16'h0010);
        repeat (7) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("rst mid outs", {alu_busy, alu_done, alu_err, calc_res}, 35'h0);
        @(negedge clk);
        n_rst = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (alu_done || alu_busy) seen++;
        end
        chk("rst mid no done", seen, 0);

        // parser_done during EXEC is ignored.
        start_op(4'h1, 5'h03, 16'hFFFD, 16'h0007);
        repeat (4) @(negedge clk);
        dtype = 4'h2; operator = 5'h01; src1 = 16'h0001; src2 = 16'h0001; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        wait_done(6, n);
        chk("ign latency", n, 17);
        chk("ign res", calc_res, 32'hFFFFFFEB);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (alu_done || alu_busy) seen++;
        end
        chk("ign no 2nd op", seen, 0);

        // parser_done in the done cycle is dropped.
        start_op(4'h2, 5'h01, 16'h0002, 16'h0003);
        wait_done(1, n);
        chk("drop latency", n, 2);
        held = calc_res;
        chk("drop res", held, 32'h00000005);
        dtype = 4'h2; operator = 5'h01; src1 = 16'h0100; src2 = 16'h0100; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        seen = 0;
        repeat (5) begin
            if (alu_done || alu_busy) seen++;
            @(negedge clk);
        end
        chk("drop no op", seen, 0);
        chk("drop res held", calc_res, 32'h00000005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
